// File: rtl/button_event_arbiter.sv
// Button event arbiter: synchronizes and debounces N_CH raw button levels,
// turns each accepted level change into a press/release event held in a
// one-entry slot per channel, and arbitrates the slots round-robin onto a
// single valid/ready event output. A dropped event sets a sticky overflow flag.
module button_event_arbiter #(
  parameter int N_CH      = 4,
  parameter int DB_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_CH-1:0]         btn_raw,
  input  logic                    evt_ready,
  input  logic                    clr_overflow,
  output logic                    evt_valid,
  output logic [$clog2(N_CH)-1:0] evt_ch,
  output logic                    evt_type,
  output logic [N_CH-1:0]         btn_state,
  output logic                    overflow
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);

  logic [N_CH-1:0]  sync1_r;
  logic [N_CH-1:0]  sync2_r;
  logic [CNT_W-1:0] cnt_r     [N_CH];
  logic [CNT_W-1:0] cnt_nxt_s [N_CH];
  logic [N_CH-1:0]  btn_state_r;
  logic [N_CH-1:0]  toggle_s;

  logic [N_CH-1:0]  occ_r;
  logic [N_CH-1:0]  typ_r;
  logic [N_CH-1:0]  drain_s;
  logic             drop_s;
  logic             overflow_r;

  logic             evt_valid_r;
  logic [CH_W-1:0]  evt_ch_r;
  logic             evt_type_r;
  logic [CH_W-1:0]  last_r;
  logic             load_s;
  logic             grant_s;
  logic [CH_W-1:0]  grant_ch_s;

  assign evt_valid = evt_valid_r;
  assign evt_ch    = evt_ch_r;
  assign evt_type  = evt_type_r;
  assign btn_state = btn_state_r;
  assign overflow  = overflow_r;

  // Debounce: count consecutive disagreeing edges, toggle on the last one.
  always_comb begin
    toggle_s = '0;
    for (int c = 0; c < N_CH; c++) begin
      cnt_nxt_s[c] = '0;
      if (sync2_r[c] != btn_state_r[c]) begin
        if (cnt_r[c] == CNT_LAST) begin
          toggle_s[c]  = 1'b1;
          cnt_nxt_s[c] = '0;
        end else begin
          cnt_nxt_s[c] = cnt_r[c] + CNT_ONE;
        end
      end else begin
        cnt_nxt_s[c] = '0;
      end
    end
  end

  // Synchronizer flops, debounce counters and debounced levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r     <= '0;
      sync2_r     <= '0;
      btn_state_r <= '0;
      for (int c = 0; c < N_CH; c++) begin
        cnt_r[c] <= '0;
      end
    end else begin
      sync1_r     <= btn_raw;
      sync2_r     <= sync1_r;
      btn_state_r <= btn_state_r ^ toggle_s;
      for (int c = 0; c < N_CH; c++) begin
        cnt_r[c] <= cnt_nxt_s[c];
      end
    end
  end

  // Round-robin search for the first occupied slot after the last grant.
  always_comb begin
    load_s     = ~evt_valid_r | evt_ready;
    grant_s    = 1'b0;
    grant_ch_s = '0;
    for (int i = 1; i <= N_CH; i++) begin
      int               sum;
      logic [CH_W-1:0]  idx;
      sum = int'(last_r) + i;
      sum = (sum >= N_CH) ? (sum - N_CH) : sum;
      idx = CH_W'(sum);
      if (!grant_s && occ_r[idx]) begin
        grant_s    = 1'b1;
        grant_ch_s = idx;
      end else begin
        grant_s    = grant_s;
        grant_ch_s = grant_ch_s;
      end
    end
  end

  // Per-channel drain strobes and overflow detection.
  always_comb begin
    drain_s = '0;
    for (int c = 0; c < N_CH; c++) begin
      drain_s[c] = load_s & grant_s & (grant_ch_s == CH_W'(c));
    end
    drop_s = |(toggle_s & occ_r & ~drain_s);
  end

  // Event slots: a drained slot may accept a new event on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_r <= '0;
      typ_r <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (toggle_s[c] && (!occ_r[c] || drain_s[c])) begin
          occ_r[c] <= 1'b1;
          typ_r[c] <= ~btn_state_r[c];
        end else if (drain_s[c]) begin
          occ_r[c] <= 1'b0;
        end
      end
    end
  end

  // Sticky overflow flag; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (clr_overflow) begin
      overflow_r <= 1'b0;
    end
  end

  // Output register and round-robin pointer; channel 0 wins first after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid_r <= 1'b0;
      evt_ch_r    <= '0;
      evt_type_r  <= 1'b0;
      last_r      <= LAST_CH;
    end else if (load_s) begin
      if (grant_s) begin
        evt_valid_r <= 1'b1;
        evt_ch_r    <= grant_ch_s;
        evt_type_r  <= typ_r[grant_ch_s];
        last_r      <= grant_ch_s;
      end else begin
        evt_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench for button_event_arbiter: a cycle-level behavioural
// model is compared against the DUT every cycle, plus directed literal checks.
module tb_button_event_arbiter;

  localparam int N  = 4;
  localparam int DB = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] btn_raw;
  logic         evt_ready;
  logic         clr_overflow;
  logic         evt_valid;
  logic [1:0]   evt_ch;
  logic         evt_type;
  logic [N-1:0] btn_state;
  logic         overflow;

  button_event_arbiter #(.N_CH(N), .DB_CYCLES(DB)) dut (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw), .evt_ready(evt_ready),
    .clr_overflow(clr_overflow), .evt_valid(evt_valid), .evt_ch(evt_ch),
    .evt_type(evt_type), .btn_state(btn_state), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_no = 0;
  bit run_cmp = 1'b0;

  // behavioural model state
  logic [N-1:0] m_d1, m_d2;
  logic [N-1:0] m_state;
  int           m_run [N];
  bit           m_occ [N];
  bit           m_typ [N];
  bit           m_out_v;
  int           m_out_c;
  bit           m_out_t;
  bit           m_ovf;
  int           m_last;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_no, act, exp);
    end
  endtask

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_state = '0;
    for (int c = 0; c < N; c++) begin
      m_run[c] = 0; m_occ[c] = 1'b0; m_typ[c] = 1'b0;
    end
    m_out_v = 1'b0; m_out_c = 0; m_out_t = 1'b0; m_ovf = 1'b0;
    m_last = N - 1;
  endtask

  // One rising edge of the reference behaviour, using inputs as seen at the edge.
  task automatic model_step();
    logic [N-1:0] lvl;
    bit           newev [N];
    bit           dropped;
    bit           loadable;
    int           g;
    lvl = m_d2;
    m_d2 = m_d1;
    m_d1 = btn_raw;
    for (int c = 0; c < N; c++) begin
      newev[c] = 1'b0;
      if (lvl[c] != m_state[c]) begin
        m_run[c]++;
        if (m_run[c] == DB) begin
          m_state[c] = ~m_state[c];
          m_run[c]   = 0;
          newev[c]   = 1'b1;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    loadable = !m_out_v || evt_ready;
    g = -1;
    if (loadable) begin
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (m_last + i) % N;
        if (g < 0 && m_occ[c]) g = c;
      end
      if (g >= 0) begin
        m_out_v = 1'b1; m_out_c = g; m_out_t = m_typ[g];
        m_occ[g] = 1'b0; m_last = g;
      end else begin
        m_out_v = 1'b0;
      end
    end
    dropped = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (newev[c]) begin
        if (m_occ[c]) dropped = 1'b1;
        else begin m_occ[c] = 1'b1; m_typ[c] = m_state[c]; end
      end
    end
    if (dropped) m_ovf = 1'b1;
    else if (clr_overflow) m_ovf = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    edge_no++;
  endtask

  // Cycle-by-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      check("btn_state", int'(btn_state), int'(m_state));
      check("evt_valid", int'(evt_valid), int'(m_out_v));
      check("overflow", int'(overflow), int'(m_ovf));
      if (m_out_v) begin
        check("evt_ch", int'(evt_ch), m_out_c);
        check("evt_type", int'(evt_type), int'(m_out_t));
      end
    end
  end

  int  seen;
  int  n_ev;
  int  ev_ch [8];
  int  ev_ty [8];
  int  ev_ed [8];

  initial begin
    reset_n = 1'b0; btn_raw = '0; evt_ready = 1'b1; clr_overflow = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset evt_valid", int'(evt_valid), 0);
    check("reset btn_state", int'(btn_state), 0);
    check("reset overflow", int'(overflow), 0);
    check("reset evt_ch", int'(evt_ch), 0);
    reset_n = 1'b1;
    run_cmp = 1'b1;
    edge_no = 0;

    // single press on ch0, first sampled at edge 10
    repeat (9) step();
    btn_raw[0] = 1'b1;
    while (edge_no < 26) step();
    check("ch0 state edge26", int'(btn_state[0]), 0);
    step();
    check("ch0 state edge27", int'(btn_state[0]), 1);
    check("valid edge27", int'(evt_valid), 0);
    step();
    check("valid edge28", int'(evt_valid), 1);
    check("ch edge28", int'(evt_ch), 0);
    check("type edge28", int'(evt_type), 1);
    step();
    check("valid edge29", int'(evt_valid), 0);
    btn_raw[0] = 1'b0;
    repeat (30) step();

    // short glitch on ch2 is rejected
    btn_raw[2] = 1'b1;
    seen = 0;
    repeat (10) begin step(); seen = seen | int'(evt_valid); end
    btn_raw[2] = 1'b0;
    repeat (30) begin step(); seen = seen | int'(evt_valid); end
    check("glitch events", seen, 0);
    check("glitch state", int'(btn_state), 0);

    // simultaneous presses on ch1 and ch3
    btn_raw[1] = 1'b1; btn_raw[3] = 1'b1;
    n_ev = 0;
    repeat (30) begin
      step();
      if (evt_valid && n_ev < 8) begin
        ev_ch[n_ev] = int'(evt_ch); ev_ty[n_ev] = int'(evt_type); ev_ed[n_ev] = edge_no;
        n_ev++;
      end
    end
    check("dual count", n_ev, 2);
    check("dual first ch", ev_ch[0], 1);
    check("dual second ch", ev_ch[1], 3);
    check("dual types", ev_ty[0] + ev_ty[1], 2);
    check("dual back-to-back", ev_ed[1] - ev_ed[0], 1);
    check("dual overflow", int'(overflow), 0);
    btn_raw[1] = 1'b0; btn_raw[3] = 1'b0;
    repeat (30) step();

    // backpressure: press, release, press on ch2 with evt_ready low
    evt_ready = 1'b0;
    btn_raw[2] = 1'b1; repeat (20) step();
    btn_raw[2] = 1'b0; repeat (20) step();
    btn_raw[2] = 1'b1; repeat (20) step();
    check("bp held valid", int'(evt_valid), 1);
    check("bp held ch", int'(evt_ch), 2);
    check("bp held type", int'(evt_type), 1);
    check("bp overflow", int'(overflow), 1);
    evt_ready = 1'b1;
    step();
    check("bp release valid", int'(evt_valid), 1);
    check("bp release ch", int'(evt_ch), 2);
    check("bp release type", int'(evt_type), 0);
    step();
    check("bp drained", int'(evt_valid), 0);
    repeat (5) step();
    check("bp overflow sticky", int'(overflow), 1);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("bp overflow cleared", int'(overflow), 0);
    btn_raw[2] = 1'b0;
    repeat (30) step();

    // asynchronous reset with a presented event and an occupied slot
    evt_ready = 1'b0;
    btn_raw[0] = 1'b1; btn_raw[1] = 1'b1;
    repeat (20) step();
    check("pre-reset valid", int'(evt_valid), 1);
    btn_raw = '0;
    step();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("mid reset valid", int'(evt_valid), 0);
    check("mid reset ch", int'(evt_ch), 0);
    check("mid reset type", int'(evt_type), 0);
    check("mid reset state", int'(btn_state), 0);
    check("mid reset overflow", int'(overflow), 0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    evt_ready = 1'b1;
    seen = 0;
    repeat (40) begin step(); seen = seen | int'(evt_valid); end
    check("post reset events", seen, 0);

    // button held high through reset yields exactly one press
    btn_raw[3] = 1'b1;
    reset_n = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    n_ev = 0;
    repeat (40) begin
      step();
      if (evt_valid && n_ev < 8) begin
        ev_ch[n_ev] = int'(evt_ch); ev_ty[n_ev] = int'(evt_type);
        n_ev++;
      end
    end
    check("held count", n_ev, 1);
    check("held ch", ev_ch[0], 3);
    check("held type", ev_ty[0], 1);

    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 Parameter N_CH, default 4, number of button channels (2..16).
REQ-002 Parameter DB_CYCLES, default 16, consecutive stable cycles needed to accept a level change (2..65535).
REQ-003 Port clk  input  1  system clock, all state on rising edge.
REQ-004 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port btn_raw  input  N_CH  raw, asynchronous, bouncing button levels, one bit per channel.
REQ-006 Port evt_ready  input  1  consumer accepts the presented event.
REQ-007 Port clr_overflow  input  1  synchronous clear of the overflow flag.
REQ-008 Port evt_valid  output  1  an event is presented on evt_ch/evt_type.
REQ-009 Port evt_ch  output  ceil(log2(N_CH))  channel index of the presented event.
REQ-010 Port evt_type  output  1  1 = press (0->1), 0 = release (1->0).
REQ-011 Port btn_state  output  N_CH  debounced level per channel.
REQ-012 Port overflow  output  1  sticky flag: an event was dropped.

Function
REQ-013 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Per channel, a debounce counter SHALL increment on every edge where the synchronized level differs from btn_state, and clear on any edge where they are equal.
REQ-015 btn_state SHALL toggle, and the counter SHALL clear, on the DB_CYCLES-th consecutive differing edge. Raw change first sampled at edge k gives btn_state update at edge k+DB_CYCLES+1.
REQ-016 Any disagreement shorter than DB_CYCLES cycles SHALL leave btn_state unchanged and produce no event.
REQ-017 Each channel SHALL own a one-entry event slot (occupied bit + type). On the same edge btn_state toggles, the slot SHALL load with type = new btn_state value.
REQ-018 If the slot is occupied and not being drained on that edge, the new event SHALL be dropped and overflow set. The slot keeps its old event.
REQ-019 If a slot is drained into the output register on the same edge a new edge arrives, the slot SHALL take the new event with no overflow.
REQ-020 The output register SHALL be loadable when evt_valid=0 or (evt_valid=1 and evt_ready=1).
REQ-021 When loadable, the arbiter SHALL grant the first occupied slot in round-robin order, starting at the channel after the last granted channel and wrapping N_CH-1 -> 0. The granted slot SHALL move into evt_ch/evt_type and clear on that edge, and evt_valid SHALL be 1 after it.
REQ-022 When loadable and no slot is occupied, evt_valid SHALL go 0 on that edge.
REQ-023 While evt_valid=1 and evt_ready=0, evt_ch and evt_type SHALL hold stable.
REQ-024 Sustained throughput SHALL be one event per cycle when evt_ready=1.
REQ-025 The event from the edge where btn_state toggles (k+DB_CYCLES+1) SHALL appear with evt_valid=1 after edge k+DB_CYCLES+2, if the output is loadable.
REQ-026 overflow SHALL stay 1 until clr_overflow=1. If set and clear occur on the same edge, set wins.
REQ-027 Events from one channel SHALL be delivered in occurrence order. No event SHALL be duplicated.

Reset
REQ-028 While reset_n=0, the following SHALL be 0 immediately: synchronizers, counters, btn_state, slots, evt_valid, evt_ch, evt_type, overflow.
REQ-029 During reset, the round-robin pointer SHALL be set so channel 0 has highest priority on the first grant.
REQ-030 A button held high through reset release SHALL produce one press event after normal debounce.

Verification (N_CH=4, DB_CYCLES=16, evt_ready=1 unless stated)
REQ-031 btn_raw[0] 0->1 first sampled at edge 10, held -> btn_state[0]=1 after edge 27; evt_valid=1, evt_ch=0, evt_type=1 for exactly one cycle after edge 28.
REQ-032 btn_raw[2] high for 10 cycles then low -> btn_state stays 0, evt_valid stays 0.
REQ-033 btn_raw[1] and btn_raw[3] rise in the same cycle -> consecutive cycles deliver ch1 press, then ch3 press; no overflow.
REQ-034 evt_ready=0 with ch2 pressed, released, then pressed again (each level held 20 cycles):
- output holds ch2 press;
- slot holds the release;
- second press sets overflow=1.
Then evt_ready=1 -> press, then release delivered, nothing more; clr_overflow pulse -> overflow=0.
REQ-035 reset_n pulsed low while evt_valid=1 and slots occupied -> all outputs 0 within the same cycle. With btn_raw=0 after release, no event follows.
